// File: rtl/tpu_gemm_tiled.sv
// Tiled GEMM engine: C = (A + in_offset) * B on a PE x PE output-stationary systolic array.
// Walks M/N tiles, skews operands on chip and writes one accumulator row per WRITE cycle.

module tpu_gemm_pe #(
  parameter int AOW  = 10,
  parameter int BOW  = 9,
  parameter int ACCW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic [AOW-1:0]  a_i,
  input  logic [BOW-1:0]  b_i,
  output logic [ACCW-1:0] acc_o
);
  localparam int PW = AOW + BOW;

  logic [PW-1:0]   prod;
  logic [ACCW-1:0] prod_x;
  logic [ACCW-1:0] acc_q;

  // Both operands are signed; low PW bits of the extended product are exact.
  assign prod = {{BOW{a_i[AOW-1]}}, a_i} * {{AOW{b_i[BOW-1]}}, b_i};

  if (PW >= ACCW) begin : g_trunc
    assign prod_x = prod[ACCW-1:0];
  end else begin : g_sext
    assign prod_x = {{(ACCW-PW){prod[PW-1]}}, prod};
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) acc_q <= '0;
    else              acc_q <= acc_q + prod_x;
  end

  assign acc_o = acc_q;
endmodule

module tpu_gemm_tiled #(
  parameter int PE   = 4,
  parameter int DW   = 8,
  parameter int ACCW = 32,
  parameter int AW   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         K,
  input  logic [7:0]         M,
  input  logic [7:0]         N,
  input  logic [8:0]         in_offset,
  input  logic               signed_mode,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state_o,
  output logic               A_wr_en,
  output logic               B_wr_en,
  output logic [AW-1:0]      A_index,
  output logic [AW-1:0]      B_index,
  input  logic [PE*DW-1:0]   A_data_out,
  input  logic [PE*DW-1:0]   B_data_out,
  output logic               C_wr_en,
  output logic [AW-1:0]      C_index,
  output logic [PE*ACCW-1:0] C_data_in
);
  localparam int XW  = DW + 1;
  localparam int AOW = ((XW > 9) ? XW : 9) + 1;
  localparam int CW  = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FEED = 3'd1, S_FLUSH = 3'd2, S_WRITE = 3'd3, S_DONE = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    mt_q, mt_d, nt_q, nt_d;
  logic [7:0]    k_q, k_d, m_q, m_d, n_q, n_d;
  logic [8:0]    off_q, off_d;
  logic          sgn_q, sgn_d;
  logic          rd_vld_q;
  logic [8:0]    mt_cnt, nt_cnt;
  logic          last_write;

  assign mt_cnt     = ({1'b0, m_q} + 9'(PE-1)) / 9'(PE);
  assign nt_cnt     = ({1'b0, n_q} + 9'(PE-1)) / 9'(PE);
  assign last_write = (state_q == S_WRITE) && (cnt_q == CW'(PE-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mt_q     <= '0;
      nt_q     <= '0;
      k_q      <= '0;
      m_q      <= '0;
      n_q      <= '0;
      off_q    <= '0;
      sgn_q    <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mt_q     <= mt_d;
      nt_q     <= nt_d;
      k_q      <= k_d;
      m_q      <= m_d;
      n_q      <= n_d;
      off_q    <= off_d;
      sgn_q    <= sgn_d;
      rd_vld_q <= (state_q == S_FEED);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mt_d    = mt_q;
    nt_d    = nt_q;
    k_d     = k_q;
    m_d     = m_q;
    n_d     = n_q;
    off_d   = off_q;
    sgn_d   = sgn_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        k_d     = K;
        m_d     = M;
        n_d     = N;
        off_d   = in_offset;
        sgn_d   = signed_mode;
        cnt_d   = '0;
        mt_d    = '0;
        nt_d    = '0;
        state_d = (K == 8'd0 || M == 8'd0 || N == 8'd0) ? S_DONE : S_FEED;
      end
      S_FEED: begin
        if (cnt_q == CW'(k_q - 8'd1)) begin
          cnt_d   = '0;
          state_d = S_FLUSH;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_FLUSH: begin
        if (cnt_q == CW'(2*PE-2)) begin
          cnt_d   = '0;
          state_d = S_WRITE;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_WRITE: begin
        if (last_write) begin
          cnt_d   = '0;
          state_d = S_FEED;
          if ({1'b0, nt_q} == nt_cnt - 9'd1) begin
            nt_d = '0;
            if ({1'b0, mt_q} == mt_cnt - 9'd1) state_d = S_DONE;
            else                               mt_d    = mt_q + 8'd1;
          end else nt_d = nt_q + 8'd1;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Row inputs after skew (A) and column inputs after skew (B).
  logic [PE-1:0][AOW-1:0]        a_row;
  logic [PE-1:0][XW-1:0]         b_col;
  logic [PE-1:0][PE-1:0][AOW-1:0] a_in;
  logic [PE-1:0][PE-1:0][XW-1:0]  b_in;
  logic [PE-1:0][PE-2:0][AOW-1:0] a_pass_q;
  logic [PE-2:0][PE-1:0][XW-1:0]  b_pass_q;
  logic [PE-1:0][PE-1:0][ACCW-1:0] acc;

  for (genvar i = 0; i < PE; i++) begin : g_lane
    logic [DW-1:0]  a_e, b_e;
    logic [AOW-1:0] a_ld;
    logic [XW-1:0]  b_ld;
    logic           a_s, b_s;

    assign a_e  = A_data_out[i*DW +: DW];
    assign b_e  = B_data_out[i*DW +: DW];
    assign a_s  = sgn_q & a_e[DW-1];
    assign b_s  = sgn_q & b_e[DW-1];
    // Offset applied before gating so flush cycles inject true zeros.
    assign a_ld = rd_vld_q ? ({{(AOW-XW){a_s}}, a_s, a_e} + {{(AOW-9){off_q[8]}}, off_q}) : '0;
    assign b_ld = rd_vld_q ? {b_s, b_e} : '0;

    if (i == 0) begin : g_nodly
      assign a_row[i] = a_ld;
      assign b_col[i] = b_ld;
    end else begin : g_dly
      logic [i-1:0][AOW-1:0] ask_q;
      logic [i-1:0][XW-1:0]  bsk_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          ask_q <= '0;
          bsk_q <= '0;
        end else begin
          ask_q[0] <= a_ld;
          bsk_q[0] <= b_ld;
          for (int d = 1; d < i; d++) begin
            ask_q[d] <= ask_q[d-1];
            bsk_q[d] <= bsk_q[d-1];
          end
        end
      end
      assign a_row[i] = ask_q[i-1];
      assign b_col[i] = bsk_q[i-1];
    end
  end

  for (genvar i = 0; i < PE; i++) begin : g_row
    for (genvar j = 0; j < PE; j++) begin : g_col
      if (j == 0) begin : g_aw
        assign a_in[i][j] = a_row[i];
      end else begin : g_ap
        assign a_in[i][j] = a_pass_q[i][j-1];
      end
      if (i == 0) begin : g_bn
        assign b_in[i][j] = b_col[j];
      end else begin : g_bp
        assign b_in[i][j] = b_pass_q[i-1][j];
      end
      tpu_gemm_pe #(.AOW(AOW), .BOW(XW), .ACCW(ACCW)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr_i (last_write),
        .a_i   (a_in[i][j]),
        .b_i   (b_in[i][j]),
        .acc_o (acc[i][j])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_pass_q <= '0;
      b_pass_q <= '0;
    end else begin
      for (int i = 0; i < PE; i++) begin
        for (int j = 0; j < PE-1; j++) begin
          a_pass_q[i][j] <= a_in[i][j];
          b_pass_q[j][i] <= b_in[j][i];
        end
      end
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign state_o = state_q;
  assign A_wr_en = 1'b0;
  assign B_wr_en = 1'b0;
  assign C_wr_en = (state_q == S_WRITE);

  always_comb begin
    A_index   = '0;
    B_index   = '0;
    C_index   = '0;
    C_data_in = '0;
    if (state_q == S_FEED) begin
      A_index = AW'(mt_q) * AW'(k_q) + AW'(cnt_q);
      B_index = AW'(nt_q) * AW'(k_q) + AW'(cnt_q);
    end
    if (state_q == S_WRITE) begin
      C_index = AW'(nt_q) * AW'(mt_cnt) * AW'(PE) + AW'(mt_q) * AW'(PE) + AW'(cnt_q);
      for (int r = 0; r < PE; r++)
        if (cnt_q == CW'(r)) C_data_in = acc[r];
    end
  end
endmodule

// File: tb/tb_tpu_gemm_tiled.sv
// Scoreboard bench for tpu_gemm_tiled: directed jobs push expected C rows, a monitor pops and compares.
module tb_tpu_gemm_tiled;
  localparam int PE = 4, DW = 8, ACCW = 32, AW = 16;

  logic clk = 1'b0;
  logic rst, in_valid, signed_mode;
  logic [7:0] K, M, N;
  logic [8:0] in_offset;
  logic busy, done, A_wr_en, B_wr_en, C_wr_en;
  logic [2:0] state_o;
  logic [AW-1:0] A_index, B_index, C_index;
  logic [PE*DW-1:0] A_data_out, B_data_out;
  logic [PE*ACCW-1:0] C_data_in;

  logic [PE*DW-1:0] a_mem [64];
  logic [PE*DW-1:0] b_mem [64];

  typedef struct {
    logic [AW-1:0]      idx;
    logic [PE*ACCW-1:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  int checks = 0, failures = 0;
  int ra [8][3];
  int rb [3][8];

  tpu_gemm_tiled #(.PE(PE), .DW(DW), .ACCW(ACCW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .K(K), .M(M), .N(N),
    .in_offset(in_offset), .signed_mode(signed_mode), .busy(busy), .done(done),
    .state_o(state_o), .A_wr_en(A_wr_en), .B_wr_en(B_wr_en),
    .A_index(A_index), .B_index(B_index), .A_data_out(A_data_out), .B_data_out(B_data_out),
    .C_wr_en(C_wr_en), .C_index(C_index), .C_data_in(C_data_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    A_data_out <= a_mem[A_index[5:0]];
    B_data_out <= b_mem[B_index[5:0]];
  end

  always @(negedge clk) begin
    if (!rst && C_wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL c_write_unexpected idx=%0d data=%h", C_index, C_data_in);
      end else begin
        e = exp_q.pop_front();
        if (C_index !== e.idx || C_data_in !== e.data) begin
          failures++;
          $display("FAIL c_row got idx=%0d data=%h want idx=%0d data=%h",
                   C_index, C_data_in, e.idx, e.data);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic push_row(input int idx, input logic [31:0] val);
    exp_t x;
    x.idx  = AW'(idx);
    x.data = {PE{val}};
    exp_q.push_back(x);
  endtask

  // Reference for the 8x8, K=3 job: plain matrix product with offset on A.
  task automatic push_tile(input int mt, input int nt, input int off);
    exp_t x;
    for (int r = 0; r < PE; r++) begin
      x.idx = AW'(nt*8 + mt*4 + r);
      for (int c = 0; c < PE; c++) begin
        int s = 0;
        for (int k = 0; k < 3; k++) s += (ra[mt*4+r][k] + off) * rb[k][nt*4+c];
        x.data[c*ACCW +: ACCW] = 32'(s);
      end
      exp_q.push_back(x);
    end
  endtask

  task automatic start_job(input int k, input int m, input int n, input logic [8:0] off, input logic sgn);
    @(negedge clk);
    K = 8'(k); M = 8'(m); N = 8'(n); in_offset = off; signed_mode = sgn; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_job(input string nm, input int k, input int m, input int n,
                         input logic [8:0] off, input logic sgn, input int exp_busy, input bit pulse_mid);
    int bcnt = 0, dcnt = 0, cyc = 0;
    start_job(k, m, n, off, sgn);
    while (busy && cyc < 3000) begin
      bcnt++;
      if (done) dcnt++;
      if (pulse_mid && bcnt == 3) begin in_valid = 1'b1; K = 8'd0; end
      if (pulse_mid && bcnt == 4) begin in_valid = 1'b0; K = 8'(k); end
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_busy_cycles"}, 128'(bcnt), 128'(exp_busy));
    chk({nm, "_done_pulses"}, 128'(dcnt), 128'd1);
    chk({nm, "_idle_after"}, 128'(state_o), 128'd0);
    chk({nm, "_rows_missing"}, 128'(exp_q.size()), 128'd0);
    exp_q.delete();
  endtask

  task automatic load_8x8();
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 3; k++) ra[i][k] = int'($urandom_range(0, 255)) - 128;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 8; j++) rb[k][j] = int'($urandom_range(0, 255)) - 128;
    for (int t = 0; t < 2; t++)
      for (int k = 0; k < 3; k++)
        for (int l = 0; l < PE; l++) begin
          a_mem[t*3+k][l*DW +: DW] = 8'(ra[t*4+l][k]);
          b_mem[t*3+k][l*DW +: DW] = 8'(rb[k][t*4+l]);
        end
  endtask

  initial begin
    int cyc;
    bit bad;
    rst = 1'b1; in_valid = 1'b0; K = '0; M = '0; N = '0; in_offset = '0; signed_mode = 1'b0;
    for (int w = 0; w < 64; w++) begin a_mem[w] = '0; b_mem[w] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_cwr", 128'(C_wr_en), 128'd0);
    chk("rst_state", 128'(state_o), 128'd0);
    chk("rst_idx", {A_index, B_index, C_index}, 128'd0);
    chk("rst_cdata", 128'(C_data_in), 128'd0);
    rst = 1'b0;

    // A all 1, B all 2, K=4: each lane 4*2 = 8
    for (int w = 0; w < 4; w++) begin a_mem[w] = {PE{8'h01}}; b_mem[w] = {PE{8'h02}}; end
    for (int r = 0; r < 4; r++) push_row(r, 32'd8);
    run_job("ones", 4, 4, 4, 9'd0, 1'b1, 16, 1'b0);
    // same job with an in_valid pulse (K=0) mid-job; must be ignored
    for (int r = 0; r < 4; r++) push_row(r, 32'd8);
    run_job("ignore_iv", 4, 4, 4, 9'd0, 1'b1, 16, 1'b1);

    // -128 + 128 offset = 0 regardless of B
    for (int w = 0; w < 4; w++) begin a_mem[w] = {PE{8'h80}}; b_mem[w] = $urandom; end
    for (int r = 0; r < 4; r++) push_row(r, 32'd0);
    run_job("offset", 4, 4, 4, 9'd128, 1'b1, 16, 1'b0);

    // K=1, 0xFF * 0x01: -1 signed, 255 unsigned; busy 1+11+1
    a_mem[0] = {PE{8'hFF}}; b_mem[0] = {PE{8'h01}};
    for (int r = 0; r < 4; r++) push_row(r, 32'hFFFF_FFFF);
    run_job("k1_signed", 1, 4, 4, 9'd0, 1'b1, 13, 1'b0);
    for (int r = 0; r < 4; r++) push_row(r, 32'd255);
    run_job("k1_unsigned", 1, 4, 4, 9'd0, 1'b0, 13, 1'b0);

    run_job("k0", 0, 4, 4, 9'd0, 1'b1, 1, 1'b0);

    // 8x8, K=3, offset -3: tile order mt0nt0, mt0nt1, mt1nt0, mt1nt1
    load_8x8();
    push_tile(0, 0, -3); push_tile(0, 1, -3); push_tile(1, 0, -3); push_tile(1, 1, -3);
    run_job("gemm8", 3, 8, 8, 9'h1FD, 1'b1, 57, 1'b0);

    // reset during FLUSH of the second tile
    load_8x8();
    push_tile(0, 0, 5);
    start_job(3, 8, 8, 9'd5, 1'b1);
    cyc = 0;
    while (state_o != 3'd3 && cyc < 200) begin @(negedge clk); cyc++; end
    while (state_o != 3'd2 && cyc < 200) begin @(negedge clk); cyc++; end
    chk("reach_tile2_flush", 128'(cyc < 200), 128'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_state", 128'(state_o), 128'd0);
    chk("midrst_busy", 128'(busy), 128'd0);
    rst = 1'b0;
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (C_wr_en || done || busy) bad = 1'b1;
    end
    chk("midrst_quiet", 128'(bad), 128'd0);
    chk("midrst_rows_missing", 128'(exp_q.size()), 128'd0);
    exp_q.delete();

    push_tile(0, 0, 5); push_tile(0, 1, 5); push_tile(1, 0, 5); push_tile(1, 1, 5);
    run_job("after_rst", 3, 8, 8, 9'd5, 1'b1, 57, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
